mem_stage: RTL and testbench

- Consumer end of the EX/MEM pipeline latch. Takes the latched ALU result, branch-target adder value, store data, destination register and control signals.
- Resolves branches and drives a ready/request handshake to data memory, holding the pipeline while an access is outstanding.
- Registers the result into the MEM/WB boundary for the writeback stage.

---
 rtl/mem_stage.sv | 124 ++++++++++++
 tb/tb_mem_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: resolves branches, runs one data-memory access at a time, registers the MEM/WB boundary.
// ALU ops land in MEM/WB after 1 cycle. Memory ops stall upstream from issue until dmem_ready or MAX_WAIT timeout.
module mem_stage #(
    parameter int DW       = 32,
    parameter int RDW      = 4,
    parameter int SIGW     = 11,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [3:0]      br,
    input  logic [3:0]      br_cond,
    input  logic [3:0]      alu_cond,
    input  logic [DW-1:0]   alu,
    input  logic [DW-1:0]   adder,
    input  logic [DW-1:0]   writedata,
    input  logic [RDW-1:0]  rd,
    input  logic [SIGW-1:0] signals,
    output logic            stall,
    output logic            pc_src,
    output logic [DW-1:0]   pc_target,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [DW-1:0]   dmem_addr,
    output logic [DW-1:0]   dmem_wdata,
    input  logic            dmem_ready,
    input  logic [DW-1:0]   dmem_rdata,
    output logic            wb_valid,
    output logic [RDW-1:0]  wb_rd,
    output logic [DW-1:0]   wb_result,
    output logic            wb_reg_write,
    output logic [SIGW-5:0] wb_signals,
    output logic            mem_err
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic [DW-1:0]   addr;
        logic [DW-1:0]   wdata;
        logic            we;
        logic [RDW-1:0]  rd;
        logic            reg_write;
        logic            mem_to_reg;
        logic [SIGW-5:0] pass;
    } req_t;

    state_t        state;
    req_t          req_q;
    logic [CW-1:0] wait_cnt;
    logic          mem_op;
    logic          use_rdata;

    assign mem_op    = in_valid & (signals[0] | signals[1]);
    assign pc_src    = in_valid & (|br) & (|(br_cond & alu_cond));
    assign pc_target = adder;

    // Gated by rst_n so a held upstream memory op cannot keep stall high during reset.
    assign stall = rst_n & ((state == ACCESS) | mem_op);

    assign dmem_addr  = req_q.addr;
    assign dmem_wdata = req_q.wdata;
    assign dmem_we    = req_q.we;
    assign use_rdata  = ~req_q.we & req_q.mem_to_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_q        <= '0;
            wait_cnt     <= '0;
            dmem_req     <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_result    <= '0;
            wb_reg_write <= 1'b0;
            wb_signals   <= '0;
            mem_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (mem_op) begin
                        state    <= ACCESS;
                        dmem_req <= 1'b1;
                        wb_valid <= 1'b0;
                        // A set mem_write bit makes it a store even if mem_read is also set.
                        req_q    <= '{addr: alu, wdata: writedata, we: signals[1], rd: rd,
                                      reg_write: signals[2], mem_to_reg: signals[3],
                                      pass: signals[SIGW-1:4]};
                    end else begin
                        wb_valid <= in_valid;
                        if (in_valid) begin
                            wb_rd        <= rd;
                            wb_result    <= alu;
                            wb_reg_write <= signals[2];
                            wb_signals   <= signals[SIGW-1:4];
                        end
                    end
                end
                ACCESS: begin
                    if (dmem_ready || wait_cnt == CW'(MAX_WAIT - 1)) begin
                        state      <= IDLE;
                        dmem_req   <= 1'b0;
                        wb_valid   <= 1'b1;
                        wb_rd      <= req_q.rd;
                        wb_signals <= req_q.pass;
                        if (dmem_ready) begin
                            wb_result    <= use_rdata ? dmem_rdata : req_q.addr;
                            wb_reg_write <= req_q.reg_write;
                        end else begin
                            wb_result    <= '0;
                            wb_reg_write <= 1'b0;
                            mem_err      <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand sequences for branch/reset, randomized ops against a reference model.
module tb_mem_stage;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  br = '0, br_cond = '0, alu_cond = '0;
    logic [31:0] alu = '0, adder = '0, writedata = '0;
    logic [3:0]  rd = '0;
    logic [10:0] signals = '0;
    logic        stall, pc_src;
    logic [31:0] pc_target;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid, wb_reg_write, mem_err;
    logic [3:0]  wb_rd;
    logic [31:0] wb_result;
    logic [6:0]  wb_signals;

    mem_stage #(.DW(32), .RDW(4), .SIGW(11), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .br(br), .br_cond(br_cond),
        .alu_cond(alu_cond), .alu(alu), .adder(adder), .writedata(writedata), .rd(rd),
        .signals(signals), .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_result(wb_result), .wb_reg_write(wb_reg_write), .wb_signals(wb_signals),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Plays the upstream latch and the memory: holds the op while stalled, answers after lat access cycles.
    task automatic run_op(input logic [10:0] sig, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] r, input int lat, input logic [31:0] rdata,
                          output int st, output int rq, output int bad_bus);
        bit is_mem;
        bit done;
        int acc;
        is_mem = sig[0] | sig[1];
        done = 1'b0;
        acc = 0;
        st = 0; rq = 0; bad_bus = 0;
        in_valid = 1'b1; signals = sig; alu = a; writedata = wd; rd = r;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall) st++;
            if (dmem_req) begin
                acc++; rq++;
                if (dmem_addr !== a || dmem_wdata !== wd || dmem_we !== sig[1]) bad_bus++;
                dmem_ready = (acc == lat);
                dmem_rdata = rdata;
            end
            done = !is_mem || (dmem_req && (acc == lat || acc == MW));
            @(posedge clk); #1;
            dmem_ready = 1'b0;
        end
        in_valid = 1'b0;
        if (!done) chk("op_bound", 32'd0, 32'd1);
        #1;
    endtask

    typedef struct {
        logic [10:0] sig;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  r;
        int          lat;
        logic [31:0] rdata;
        logic [31:0] e_res;
        logic        e_rw;
        int          e_st;
        int          e_rq;
        logic        e_err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int st, rq, bad;
        bit timed, err_m, is_mem, store;
        int kind, lat;
        logic [10:0] s;
        logic [31:0] a, wd, rdat, e_res;
        logic [3:0]  r;
        logic        e_rw;
        int          e_st;

        //         sig      alu            wdata          rd  lat rdata          result         rw  st rq err
        tbl[0] = '{11'h004, 32'h0000_1234, 32'h0,         4'd5,  0, 32'h0,         32'h0000_1234, 1'b1, 0, 0, 1'b0};
        tbl[1] = '{11'h00D, 32'h0000_0040, 32'h0,         4'd2,  3, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 4, 3, 1'b0};
        tbl[2] = '{11'h002, 32'h0000_0080, 32'hDEAD_BEEF, 4'd7,  1, 32'h0,         32'h0000_0080, 1'b0, 2, 1, 1'b0};
        tbl[3] = '{11'h005, 32'h0000_0044, 32'h0,         4'd3,  2, 32'h0000_0011, 32'h0000_0044, 1'b1, 3, 2, 1'b0};
        tbl[4] = '{11'h00F, 32'h0000_0090, 32'h0000_0055, 4'd8,  1, 32'h0000_0099, 32'h0000_0090, 1'b1, 2, 1, 1'b0};
        tbl[5] = '{11'h00D, 32'h0000_0048, 32'h0,         4'd4,  4, 32'h1234_5678, 32'h1234_5678, 1'b1, 5, 4, 1'b0};
        tbl[6] = '{11'h00D, 32'h0000_004C, 32'h0,         4'd6, 99, 32'h0000_0077, 32'h0,         1'b0, 5, 4, 1'b1};
        tbl[7] = '{11'h00D, 32'h0000_0050, 32'h0,         4'd1,  1, 32'h0000_ABCD, 32'h0000_ABCD, 1'b1, 2, 1, 1'b1};
        tbl[8] = '{11'h7F4, 32'hFFFF_FFFF, 32'h0,         4'd15, 0, 32'h0,         32'hFFFF_FFFF, 1'b1, 0, 0, 1'b1};
        tbl[9] = '{11'h000, 32'h0000_0009, 32'h0,         4'd0,  0, 32'h0,         32'h0000_0009, 1'b0, 0, 0, 1'b1};

        #12;
        chk("rst_stall", stall, 0);       chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);  chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rd", wb_rd, 0);       chk("rst_wb_result", wb_result, 0);
        chk("rst_wb_rw", wb_reg_write, 0); chk("rst_wb_sig", wb_signals, 0);
        chk("rst_err", mem_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].sig, tbl[i].a, tbl[i].wd, tbl[i].r, tbl[i].lat, tbl[i].rdata, st, rq, bad);
            timed = (tbl[i].sig[1:0] != 2'b00) && (tbl[i].lat > MW);
            chk($sformatf("v%0d_valid", i), wb_valid, 1);
            chk($sformatf("v%0d_result", i), wb_result, tbl[i].e_res);
            chk($sformatf("v%0d_rw", i), wb_reg_write, tbl[i].e_rw);
            if (!timed) chk($sformatf("v%0d_rd", i), wb_rd, tbl[i].r);
            if (!timed) chk($sformatf("v%0d_sig", i), wb_signals, tbl[i].sig >> 4);
            chk($sformatf("v%0d_stall_cyc", i), st, tbl[i].e_st);
            chk($sformatf("v%0d_req_cyc", i), rq, tbl[i].e_rq);
            chk($sformatf("v%0d_bus", i), bad, 0);
            chk($sformatf("v%0d_err", i), mem_err, tbl[i].e_err);
            chk($sformatf("v%0d_stall_after", i), stall, 0);
        end

        // Idle cycle: wb_valid drops, everything else holds.
        @(posedge clk); #1;
        chk("idle_valid", wb_valid, 0);
        chk("idle_result_hold", wb_result, 32'h9);
        chk("idle_req", dmem_req, 0);
        chk("idle_addr_hold", dmem_addr, 32'h50);

        // Branch resolution is combinational.
        in_valid = 1'b1; signals = 11'h000;
        br = 4'b0100; br_cond = 4'b0100; alu_cond = 4'b0100; adder = 32'h200;
        #1;
        chk("br_taken", pc_src, 1);
        chk("br_target", pc_target, 32'h200);
        alu_cond = 4'b1000; #1;
        chk("br_not_taken", pc_src, 0);
        alu_cond = 4'b0100; in_valid = 1'b0; #1;
        chk("br_invalid", pc_src, 0);
        br = 4'b0000; in_valid = 1'b1; #1;
        chk("br_none", pc_src, 0);
        in_valid = 1'b0;

        // Reset during the second wait cycle of a load.
        @(negedge clk);
        in_valid = 1'b1; signals = 11'h00D; alu = 32'h60; rd = 4'd9; dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_req_before", dmem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_req", dmem_req, 0);
        chk("mid_stall", stall, 0);
        chk("mid_wb_valid", wb_valid, 0);
        chk("mid_err", mem_err, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(11'h004, 32'hBEEF, 32'h0, 4'd3, 0, 32'h0, st, rq, bad);
        chk("post_rst_valid", wb_valid, 1);
        chk("post_rst_result", wb_result, 32'hBEEF);
        chk("post_rst_rd", wb_rd, 3);
        chk("post_rst_stall", st, 0);

        // Randomized ops against the reference rules.
        err_m = 1'b0;
        for (int k = 0; k < 150; k++) begin
            kind = $urandom_range(2, 0);
            s = 11'($urandom);
            if (kind == 0) s[1:0] = 2'b00;
            else if (kind == 1) s[1:0] = 2'b01;
            else s[1] = 1'b1;
            a = $urandom; wd = $urandom; rdat = $urandom; r = 4'($urandom);
            lat = $urandom_range(MW + 2, 1);
            is_mem = (kind != 0);
            store = s[1];
            timed = is_mem && (lat > MW);
            if (!is_mem) e_res = a;
            else if (timed) e_res = 32'h0;
            else if (!store && s[3]) e_res = rdat;
            else e_res = a;
            e_rw = timed ? 1'b0 : s[2];
            e_st = is_mem ? 1 + ((lat < MW) ? lat : MW) : 0;
            err_m = err_m | timed;
            run_op(s, a, wd, r, lat, rdat, st, rq, bad);
            chk($sformatf("r%0d_valid", k), wb_valid, 1);
            chk($sformatf("r%0d_result", k), wb_result, e_res);
            chk($sformatf("r%0d_rw", k), wb_reg_write, e_rw);
            if (!timed) chk($sformatf("r%0d_rd", k), wb_rd, r);
            chk($sformatf("r%0d_stall_cyc", k), st, e_st);
            chk($sformatf("r%0d_req_cyc", k), rq, is_mem ? e_st - 1 : 0);
            chk($sformatf("r%0d_bus", k), bad, 0);
            chk($sformatf("r%0d_err", k), mem_err, err_m);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
